// File: rtl/semis_cmp_filter_if.sv
// Comparator filter bus: per-channel legs, controls and filtered results.
// master drives stimulus/controls, slave is the filter block.
interface semis_cmp_filter_if #(
  parameter int CH     = 4,
  parameter int FILT_W = 4
);
  logic              ena;
  logic [CH-1:0]     vip;
  logic [CH-1:0]     vin;
  logic [FILT_W-1:0] filt_len;
  logic [1:0]        mode;
  logic              clr;
  logic [CH-1:0]     cmp_out;
  logic [CH-1:0]     valid;
  logic [CH-1:0]     rise;
  logic [CH-1:0]     fall;
  logic [CH-1:0]     err_sticky;

  modport master (
    output ena, vip, vin, filt_len, mode, clr,
    input  cmp_out, valid, rise, fall, err_sticky
  );

  modport slave (
    input  ena, vip, vin, filt_len, mode, clr,
    output cmp_out, valid, rise, fall, err_sticky
  );
endinterface

// File: rtl/semis_cmp_filter.sv
// Multi-channel differential comparator with sync, glitch filter,
// edge pulses and sticky invalid-input flags.
module semis_cmp_filter #(
  parameter int CH     = 4,
  parameter int FILT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  semis_cmp_filter_if.slave bus
);

  logic [CH-1:0]     r_p1, r_p2;
  logic [CH-1:0]     r_n1, r_n2;
  logic [FILT_W-1:0] r_cnt [CH];
  logic [CH-1:0]     r_cmp;
  logic [CH-1:0]     r_valid;
  logic [CH-1:0]     r_rise;
  logic [CH-1:0]     r_fall;
  logic [CH-1:0]     r_err;

  logic [CH-1:0]     w_vraw;
  logic [CH-1:0]     w_cand;
  logic [FILT_W-1:0] w_cnt_n [CH];
  logic [CH-1:0]     w_cmp_n;
  logic [CH-1:0]     w_rise_n;
  logic [CH-1:0]     w_fall_n;
  logic [CH-1:0]     w_err_n;

  assign w_vraw = r_p2 ^ r_n2;
  assign w_cand = r_p2 ^ {CH{bus.mode[0]}};

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_cnt_n[i]  = r_cnt[i];
      w_cmp_n[i]  = r_cmp[i];
      w_rise_n[i] = 1'b0;
      w_fall_n[i] = 1'b0;
      w_err_n[i]  = r_err[i] & ~bus.clr;
      if (bus.ena) begin
        // set beats clr, so an invalid sample is never lost
        unique case (1'b1)
          !w_vraw[i]: begin
            w_cnt_n[i] = '0;
            w_err_n[i] = 1'b1;
            if (bus.mode[1] && r_cmp[i]) begin
              w_cmp_n[i]  = 1'b0;
              w_fall_n[i] = 1'b1;
            end
          end
          w_vraw[i] && (w_cand[i] == r_cmp[i]): begin
            w_cnt_n[i] = '0;
          end
          w_vraw[i] && (w_cand[i] != r_cmp[i])
            && (r_cnt[i] >= bus.filt_len): begin
            w_cnt_n[i]  = '0;
            w_cmp_n[i]  = w_cand[i];
            w_rise_n[i] = w_cand[i];
            w_fall_n[i] = ~w_cand[i];
          end
          default: begin
            w_cnt_n[i] = r_cnt[i] + FILT_W'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1    <= '0;
      r_p2    <= '0;
      r_n1    <= '0;
      r_n2    <= '0;
      r_cmp   <= '0;
      r_valid <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_err   <= '0;
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_p1    <= bus.vip;
      r_p2    <= r_p1;
      r_n1    <= bus.vin;
      r_n2    <= r_n1;
      r_valid <= w_vraw;
      r_cmp   <= w_cmp_n;
      r_rise  <= w_rise_n;
      r_fall  <= w_fall_n;
      r_err   <= w_err_n;
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= w_cnt_n[i];
      end
    end
  end

  assign bus.cmp_out    = r_cmp;
  assign bus.valid      = r_valid;
  assign bus.rise       = r_rise;
  assign bus.fall       = r_fall;
  assign bus.err_sticky = r_err;

endmodule
